comparator_serial: RTL and testbench
====================================

# comparator_serial

Multi-cycle, chunk-serial magnitude comparator for the ALU compare path. It accepts two N-bit operands with a valid/ready handshake and resolves signed or unsigned less-than and equality by walking the operands W bits per cycle, LSB chunk first. Each chunk computes a + ~b + carry on a W-bit adder slice, so the full N-bit subtractor is traded for a small adder and N/W cycles of latency. Results go to the downstream consumer (branch/SLT writeback) through a second valid/ready handshake.

## Interface
- N, 32: operand width; N % W == 0 is required (elaboration-time check).
- W, 8: chunk width processed per cycle; W == N gives a single-cycle compute.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  upstream offers a, b, is_signed.
- o_ready  out  1  block can accept; high only in IDLE.
- a  in  N  operand A.
- b  in  N  operand B.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned.
- o_valid  out  1  result valid; high only in DONE.
- i_ready  in  1  downstream accepts the result.
- out_lt  out  1  A < B under the selected signedness.
- out_eq  out  1  A == B.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: o_ready=1. When i_valid=1, latch a, b, is_signed and both MSBs; carry<=1; eq_acc<=1; chunk count<=0; go to BUSY.
- BUSY: slice = low W bits of the operand registers. The adder computes a_slice + ~b_slice + carry. carry<=c_out. eq_acc<=eq_acc & (a_slice==b_slice). Both operand registers shift right by W. Count increments. After the N/W-th BUSY cycle, go to DONE and register results.
- Result rules, using the final carry: unsigned lt = ~carry. Signed lt = (a_msb ^ b_msb) ? a_msb : ~carry. eq = eq_acc.
- DONE: o_valid=1. out_lt and out_eq are held stable. On i_ready=1, go to IDLE. Results stay valid only while o_valid=1.
- Inputs presented during BUSY or DONE are ignored. The upstream must hold them until o_ready.
- No same-cycle result release and new accept: o_ready is 0 in DONE.

## Timing
- Reset values: state=IDLE, o_ready=1, o_valid=0, out_lt=0, out_eq=0, carry=0, eq_acc=0, count=0.
- Latency: o_valid rises on the (N/W+1)-th rising edge after, and counting, the accepting edge. With N=32, W=8 that is 5 edges.
- Throughput, with i_ready held high: one compare per N/W+2 cycles. For N=32, W=8 that is 6.
- Backpressure: DONE is held indefinitely while i_ready=0. Outputs do not change.
- Reset mid-operation, in BUSY or DONE: the operation is abandoned. The next cycle shows IDLE reset values and no result is emitted.
- Reset and i_valid high in the same cycle: reset wins and nothing is accepted.
- W == N: exactly one BUSY cycle. The counter width is $clog2(N/W)+1 so it cannot wrap before reaching N/W.

## Structure
- Package comparator_pkg holds:
  - typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} comparator_state_t;
  - the N % W check helper.
- Sub-module: one adder_n #(.N(W)) instance. Its inputs are a_slice, ~b_slice and c_in=carry; its c_out feeds the carry register. No other arithmetic is instantiated.
- The FSM, shift registers, eq accumulator and output registers live in comparator_serial. Target size is about 150 lines.

## Test plan
All cases use N=32, W=8.
- Basic unsigned: a=5, b=7, unsigned -> out_lt=1, out_eq=0. o_valid rises exactly 5 edges after the accept edge.
- Signedness split: a=0xFFFFFFFF, b=0x00000001.
  - Unsigned -> out_lt=0.
  - Signed -> out_lt=1.
  - In both cases out_eq=0.
- Equal, sign boundary: a=b=0x80000000, signed -> out_lt=0, out_eq=1. Repeat unsigned -> same result.
- Cross-chunk carry: a=0x00000100, b=0x000000FF, unsigned -> out_lt=0. Swapping the operands -> out_lt=1.
- Backpressure: complete a compare and hold i_ready=0 for 3 cycles.
  - o_valid, out_lt and out_eq stay stable.
  - o_ready=0.
  - A new i_valid with different operands is ignored.
  - After i_ready=1, o_ready=1 on the next cycle.
- Reset mid-compare: assert rst on the 2nd BUSY cycle.
  - Next cycle: o_valid=0, o_ready=1, out_lt=0, out_eq=0.
  - A subsequent compare a=3, b=3 -> out_eq=1, out_lt=0.

Source files
------------

// File: rtl/comparator_pkg.sv
// ---------------------------------------------------------------------------
// comparator_pkg
// Shared types and elaboration helpers for the chunk-serial comparator.
//   comparator_state_t : FSM encoding (IDLE -> BUSY -> DONE)
//   chunking_ok()      : true when an N-bit operand splits evenly into
//                        W-bit chunks
// ---------------------------------------------------------------------------
package comparator_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } comparator_state_t;

  function automatic bit chunking_ok(input int n, input int w);
    return (w > 0) && (n >= w) && ((n % w) == 0);
  endfunction

endpackage

// File: rtl/adder_n.sv
// ---------------------------------------------------------------------------
// adder_n
// Plain N-bit ripple/carry adder slice: {c_out, sum} = a + b + c_in.
//   a, b  : N-bit addends
//   c_in  : carry in
//   sum   : N-bit sum
//   c_out : carry out of the top bit
// ---------------------------------------------------------------------------
module adder_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule

// File: rtl/comparator_serial.sv
// ---------------------------------------------------------------------------
// comparator_serial
// Multi-cycle magnitude comparator. Operands are walked W bits per cycle,
// LSB chunk first, through a single W-bit adder computing a + ~b + carry.
// The final carry out is the "no borrow" flag of A - B.
//   clk, rst           : clock, synchronous active-high reset
//   i_valid / o_ready  : upstream handshake (a, b, is_signed)
//   o_valid / i_ready  : downstream handshake (out_lt, out_eq)
//   out_lt             : A < B, signed or unsigned per is_signed
//   out_eq             : A == B
// ---------------------------------------------------------------------------
module comparator_serial
  import comparator_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         is_signed,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         out_lt,
  output logic         out_eq
);

  localparam int CHUNKS = N / W;
  // One spare bit so the counter can never wrap before reaching CHUNKS.
  localparam int CNT_W = $clog2(CHUNKS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

  if (!chunking_ok(N, W)) begin : g_bad_cfg
    $error("comparator_serial: N must be a positive multiple of W");
  end

  comparator_state_t state_q, state_d;

  logic [N-1:0]     a_q, b_q;
  logic [N-1:0]     a_shift, b_shift;
  logic             signed_q, a_msb_q, b_msb_q;
  logic             carry_q, eq_acc_q;
  logic [CNT_W-1:0] count_q;
  logic             lt_q, eq_q;

  logic [W-1:0]     a_slice, b_slice, slice_sum;
  logic             slice_c_out, slice_eq, last_chunk;
  logic             accept, final_lt;

  assign a_slice    = a_q[W-1:0];
  assign b_slice    = b_q[W-1:0];
  assign last_chunk = (count_q == LAST_CNT);
  assign accept     = (state_q == S_IDLE) && i_valid;

  adder_n #(.N(W)) u_adder (
    .a     (a_slice),
    .b     (~b_slice),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_c_out)
  );

  // a + ~b + c == (a - b) - 1 + c (mod 2^W), so the slices are equal exactly
  // when the sum is all-ones (c = 0) or all-zeros (c = 1). This reuses the
  // adder instead of building a separate W-bit equality comparator.
  assign slice_eq = (slice_sum == {W{~carry_q}});

  // Differing sign bits settle a signed compare on their own: the negative
  // operand is the smaller one. Otherwise the borrow decides.
  assign final_lt = (signed_q && (a_msb_q ^ b_msb_q)) ? a_msb_q : ~slice_c_out;

  if (CHUNKS == 1) begin : g_single_chunk
    assign a_shift = a_q;
    assign b_shift = b_q;
  end else begin : g_multi_chunk
    assign a_shift = {{W{1'b0}}, a_q[N-1:W]};
    assign b_shift = {{W{1'b0}}, b_q[N-1:W]};
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: registers take <= so every flop samples pre-edge values; a
    // blocking = here would let later statements see already-updated state.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves state_d
    // unassigned and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (i_valid)    state_d = S_BUSY;
      S_BUSY: if (last_chunk) state_d = S_DONE;
      S_DONE: if (i_ready)    state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign out_lt  = lt_q;
  assign out_eq  = eq_q;

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      carry_q  <= 1'b0;
      eq_acc_q <= 1'b0;
      count_q  <= '0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
    end else if (accept) begin
      a_q      <= a;
      b_q      <= b;
      signed_q <= is_signed;
      a_msb_q  <= a[N-1];
      b_msb_q  <= b[N-1];
      carry_q  <= 1'b1;  // +1 completes the two's-complement of b
      eq_acc_q <= 1'b1;
      count_q  <= '0;
    end else if (state_q == S_BUSY) begin
      a_q      <= a_shift;
      b_q      <= b_shift;
      carry_q  <= slice_c_out;
      eq_acc_q <= eq_acc_q & slice_eq;
      count_q  <= count_q + CNT_W'(1);
      if (last_chunk) begin
        lt_q <= final_lt;
        eq_q <= eq_acc_q & slice_eq;
      end
    end
  end

endmodule

// File: tb/tb_comparator_serial.sv
// ---------------------------------------------------------------------------
// tb_comparator_serial
// Directed vectors with hand-computed results. Each accepted compare pushes
// its expected result into a scoreboard; a monitor pops and compares on every
// downstream handshake.
// ---------------------------------------------------------------------------
module tb_comparator_serial;

  localparam int N = 32;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] a, b;
  logic         is_signed;
  logic         o_valid;
  logic         i_ready;
  logic         out_lt, out_eq;

  comparator_serial #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .out_lt    (out_lt),
    .out_eq    (out_eq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         s;
    logic         lt;
    logic         eq;
    string        name;
  } vec_t;

  typedef struct {
    logic  lt;
    logic  eq;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a result transfers on any edge where o_valid && i_ready.
  always @(negedge clk) begin
    if (!rst && o_valid === 1'b1 && i_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(o_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".lt"}, 32'(out_lt), 32'(e.lt));
        check({e.name, ".eq"}, 32'(out_eq), 32'(e.eq));
      end
    end
  end

  task automatic wait_ready();
    for (int k = 0; k < 50 && o_ready !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    if (o_ready !== 1'b1) check("ready_timeout", 32'(o_ready), 32'd1);
  endtask

  // Issue one compare; returns after the DONE state has been reached.
  task automatic issue(input vec_t v, output int edges);
    wait_ready();
    a = v.a; b = v.b; is_signed = v.s; i_valid = 1'b1;
    sb.push_back('{lt: v.lt, eq: v.eq, name: v.name});
    @(posedge clk); #1;
    i_valid = 1'b0;
    edges = 1;
    while (o_valid !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  vec_t vecs[] = '{
    '{32'd5,        32'd7,        1'b0, 1'b1, 1'b0, "u_5_7"},
    '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, "u_ffff_1"},
    '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1, 1'b0, "s_m1_1"},
    '{32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b1, "s_min_eq"},
    '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, "u_min_eq"},
    '{32'h00000100, 32'h000000FF, 1'b0, 1'b0, 1'b0, "u_100_ff"},
    '{32'h000000FF, 32'h00000100, 1'b0, 1'b1, 1'b0, "u_ff_100"},
    '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, "s_m2_m1"},
    '{32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b0, "s_max_min"},
    '{32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0, "u_7fff_8000"}
  };

  initial begin
    int   edges;
    vec_t v;

    rst = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
    a = 32'h1; b = 32'h2; is_signed = 1'b0;

    // Reset held together with i_valid: nothing may be accepted.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    check("reset.o_ready", 32'(o_ready), 32'd1);
    check("reset.o_valid", 32'(o_valid), 32'd0);
    check("reset.out_lt",  32'(out_lt),  32'd0);
    check("reset.out_eq",  32'(out_eq),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_wins.o_valid", 32'(o_valid), 32'd0);

    // Directed vectors; the first also checks latency.
    foreach (vecs[i]) begin
      issue(vecs[i], edges);
      if (i == 0) check("latency_edges", 32'(edges), 32'd5);
      check({vecs[i].name, ".done"}, 32'(o_valid), 32'd1);
      @(posedge clk); #1;
      check({vecs[i].name, ".idle"}, 32'(o_ready), 32'd1);
    end

    // Backpressure: 5 < 7 unsigned held in DONE, new operands ignored.
    i_ready = 1'b0;
    v = '{32'd5, 32'd7, 1'b0, 1'b1, 1'b0, "bp_5_7"};
    issue(v, edges);
    a = 32'd9; b = 32'd9; is_signed = 1'b1; i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("bp.o_valid", 32'(o_valid), 32'd1);
      check("bp.o_ready", 32'(o_ready), 32'd0);
      check("bp.out_lt",  32'(out_lt),  32'd1);
      check("bp.out_eq",  32'(out_eq),  32'd0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.release_o_ready", 32'(o_ready), 32'd1);
    check("bp.release_o_valid", 32'(o_valid), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("bp.ignored_no_result", 32'(o_valid), 32'd0);

    // Reset on the 2nd BUSY cycle: operation abandoned, no result emitted.
    wait_ready();
    a = 32'd1; b = 32'd1; is_signed = 1'b0; i_valid = 1'b1;
    @(posedge clk); #1;   // accept edge
    i_valid = 1'b0;
    @(posedge clk); #1;   // now in the 2nd BUSY cycle
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid.o_valid", 32'(o_valid), 32'd0);
    check("rst_mid.o_ready", 32'(o_ready), 32'd1);
    check("rst_mid.out_lt",  32'(out_lt),  32'd0);
    check("rst_mid.out_eq",  32'(out_eq),  32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("rst_mid.no_result", 32'(o_valid), 32'd0);

    v = '{32'd3, 32'd3, 1'b0, 1'b0, 1'b1, "post_rst_3_3"};
    issue(v, edges);
    check("post_rst.latency_edges", 32'(edges), 32'd5);
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Hard time limit so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "global timeout");
  end

endmodule
